uart_rx_deserializer: RTL

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

---
 rtl/uart_rx_deserializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer : 8N1 UART receiver with mid-bit sampling and framing check
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;
  logic [2:0]         bit_idx_q,   bit_idx_d;
  logic [7:0]         shift_q,     shift_d;
  logic [7:0]         data_q,      data_d;
  logic               valid_q,     valid_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_meta_q,   rx_meta_d;
  logic               rx_s_q,      rx_s_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
          // A line that is high again at mid start bit was only a glitch
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
